// File: rtl/fp16_mul_iter.sv
// Iterative binary16 multiplier: 11-step shift-add significand product, then
// normalize, round-to-nearest-even and pack with {INVALID,OVERFLOW,UNDERFLOW,INEXACT}.
module fp16_mul_iter #(
    parameter int unsigned EXP_BIAS = 15,
    parameter int unsigned MANT_W   = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              SIGN_A_HALF,
    input  logic              SIGN_B_HALF,
    input  logic [4:0]        EXP_A_HALF,
    input  logic [4:0]        EXP_B_HALF,
    input  logic [MANT_W-1:0] MANT_A_HALF,
    input  logic [MANT_W-1:0] MANT_B_HALF,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [MANT_W+5:0] RESULT_HALF,
    output logic [3:0]        FLAGS
);
    localparam int unsigned SIG_W  = MANT_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned RES_W  = MANT_W + 6;

    typedef enum logic [2:0] {S_IDLE, S_SPECIAL, S_MUL, S_NORM, S_ROUND, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [4:0]          ea_q, ea_d, eb_q, eb_d;
    logic [MANT_W-1:0]   ma_q, ma_d;
    logic [SIG_W-1:0]    b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [3:0]          cnt_q, cnt_d;
    logic signed [6:0]   e_q, e_d;
    logic [MANT_W-1:0]   frac_q, frac_d;
    logic                g_q, g_d, st_q, st_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic [3:0]          flags_q, flags_d;

    logic                in_special;
    logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic                inc, carry;
    logic [MANT_W-1:0]   frac_r;
    logic signed [6:0]   e_r;

    assign in_special = (EXP_A_HALF == 5'h1F) || (EXP_A_HALF == 5'h00) ||
                        (EXP_B_HALF == 5'h1F) || (EXP_B_HALF == 5'h00);

    // b_q still holds {1, mant_b} unshifted while in SPECIAL
    assign a_nan  = (ea_q == 5'h1F) && (ma_q != '0);
    assign b_nan  = (eb_q == 5'h1F) && (b_q[MANT_W-1:0] != '0);
    assign a_inf  = (ea_q == 5'h1F) && (ma_q == '0);
    assign b_inf  = (eb_q == 5'h1F) && (b_q[MANT_W-1:0] == '0);
    assign a_zero = (ea_q == 5'h00);
    assign b_zero = (eb_q == 5'h00);

    // Hidden bit is always 1 after NORM, so carry-out happens only when all fraction bits are 1
    assign inc    = g_q & (st_q | frac_q[0]);
    assign frac_r = frac_q + MANT_W'(inc);
    assign carry  = (&frac_q) & inc;
    assign e_r    = e_q + (carry ? 7'sd1 : 7'sd0);

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        ma_d    = ma_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        frac_d  = frac_q;
        g_d     = g_q;
        st_d    = st_q;
        res_d   = res_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    sign_d  = SIGN_A_HALF ^ SIGN_B_HALF;
                    ea_d    = EXP_A_HALF;
                    eb_d    = EXP_B_HALF;
                    ma_d    = MANT_A_HALF;
                    b_d     = {1'b1, MANT_B_HALF};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = in_special ? S_SPECIAL : S_MUL;
                end
            end
            S_SPECIAL: begin
                flags_d = 4'b0000;
                if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                    res_d   = {1'b0, 5'h1F, 1'b1, {(MANT_W-1){1'b0}}};
                    flags_d = 4'b1000;
                end else if (a_inf || b_inf) begin
                    res_d = {sign_q, 5'h1F, {MANT_W{1'b0}}};
                end else begin
                    res_d = {sign_q, {(RES_W-1){1'b0}}};
                end
                state_d = S_DONE;
            end
            S_MUL: begin
                if (b_q[0]) begin
                    acc_d = acc_q + ({{SIG_W{1'b0}}, 1'b1, ma_q} << cnt_q);
                end
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(MANT_W)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                e_d = 7'({2'b00, ea_q}) + 7'({2'b00, eb_q}) - 7'(EXP_BIAS);
                if (acc_q[PROD_W-1]) begin
                    e_d    = e_d + 7'sd1;
                    frac_d = acc_q[PROD_W-2 -: MANT_W];
                    g_d    = acc_q[MANT_W];
                    st_d   = |acc_q[MANT_W-1:0];
                end else begin
                    frac_d = acc_q[PROD_W-3 -: MANT_W];
                    g_d    = acc_q[MANT_W-1];
                    st_d   = |acc_q[MANT_W-2:0];
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (e_r >= 7'sd31) begin
                    res_d   = {sign_q, 5'h1F, {MANT_W{1'b0}}};
                    flags_d = 4'b0101;
                end else if (e_r <= 7'sd0) begin
                    res_d   = {sign_q, {(RES_W-1){1'b0}}};
                    flags_d = 4'b0011;
                end else begin
                    res_d   = {sign_q, e_r[4:0], frac_r};
                    flags_d = {3'b000, g_q | st_q};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (OUT_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            sign_q  <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            ma_q    <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            e_q     <= '0;
            frac_q  <= '0;
            g_q     <= 1'b0;
            st_q    <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            ma_q    <= ma_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            frac_q  <= frac_d;
            g_q     <= g_d;
            st_q    <= st_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign IN_READY    = (state_q == S_IDLE);
    assign OUT_VALID   = (state_q == S_DONE);
    assign RESULT_HALF = res_q;
    assign FLAGS       = flags_q;

endmodule
